// File: rtl/mem_if_pkg.sv
// Shared types for the memory interface: FSM state encoding, access-size codes
// and the alignment rule used to reject requests before they reach the bus.
package mem_if_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT_R = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERR    = 3'd4
  } state_e;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  // Size code 11 is reported as misaligned so it takes the same error path.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = addr_lo[0];
      SZ_W:    misaligned = |addr_lo;
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: byte enables and replicated store data for the
// bus, plus lane selection and sign/zero extension of returned load data.
module mem_lane_align
  import mem_if_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        uns_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    rdata_o = rdata_i;
    lane_b  = rdata_i[{addr_lo_i, 3'b000} +: 8];
    lane_h  = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (size_i)
      SZ_B: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{~uns_i & lane_b[7]}}, lane_b};
      end
      SZ_H: begin
        be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{~uns_i & lane_h[15]}}, lane_h};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_if.sv
// Load/store bus master: one transaction at a time, IDLE->REQ->(WAIT_R)->DONE,
// misaligned/illegal requests go straight to ERR. Define MEM_IF_TIMEOUT_EN to
// abort stalled bus transactions to ERR after TIMEOUT_CYC cycles.
module mem_if
  import mem_if_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [1:0]  i_size,
  input  logic        i_uns,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_done,
  output logic        o_busy,
  output logic        o_err,
  output logic        o_bus_valid,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  output logic [3:0]  o_bus_be,
  input  logic        i_bus_ready,
  input  logic        i_bus_rvalid,
  input  logic [31:0] i_bus_rdata
);

  state_e      state_q, state_d;
  logic        we_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;
  logic        timeout_hit;

  mem_lane_align u_lane (
    .size_i    (size_q),
    .addr_lo_i (addr_q[1:0]),
    .uns_i     (uns_q),
    .wdata_i   (wdata_q),
    .rdata_i   (i_bus_rdata),
    .be_o      (lane_be),
    .wdata_o   (lane_wdata),
    .rdata_o   (lane_rdata)
  );

`ifdef MEM_IF_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts cycles spent on the bus; it is zero in IDLE, so it is clear on entering REQ.
  always_comb cnt_d = (state_q == ST_REQ || state_q == ST_WAIT_R) ? cnt_q + 1'b1 : '0;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Bus handshakes take priority over a timeout landing in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (i_req) state_d = misaligned(i_size, i_addr[1:0]) ? ST_ERR : ST_REQ;
      ST_REQ:    if (i_bus_ready) state_d = we_q ? ST_DONE : ST_WAIT_R;
                 else if (timeout_hit) state_d = ST_ERR;
      ST_WAIT_R: if (i_bus_rvalid) state_d = ST_DONE;
                 else if (timeout_hit) state_d = ST_ERR;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= SZ_B;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && i_req) begin
        we_q    <= i_we;
        uns_q   <= i_uns;
        size_q  <= i_size;
        addr_q  <= i_addr;
        wdata_q <= i_wdata;
      end
      if (state_q == ST_WAIT_R && i_bus_rvalid) rdata_q <= lane_rdata;
    end
  end

  // Bus fields are forced to zero whenever no request is on the bus.
  assign o_bus_valid = (state_q == ST_REQ);
  assign o_bus_we    = o_bus_valid & we_q;
  assign o_bus_addr  = o_bus_valid ? {addr_q[31:2], 2'b00} : 32'h0;
  assign o_bus_wdata = o_bus_valid ? lane_wdata : 32'h0;
  assign o_bus_be    = o_bus_valid ? lane_be : 4'h0;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_done      = (state_q == ST_DONE) || (state_q == ST_ERR);
  assign o_err       = (state_q == ST_ERR);
  assign o_rdata     = rdata_q;

endmodule

// File: tb/tb_mem_if.sv
// Directed bench for mem_if: a cycle timeline model predicts every output and a
// negedge compare process checks it; literal checks pin the model's arithmetic.
module tb_mem_if;
  import mem_if_pkg::*;

  localparam int TO  = 4;
  localparam int TLN = 4096;

  logic        clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic        i_req = 1'b0, i_we = 1'b0, i_uns = 1'b0;
  logic [1:0]  i_size = 2'b00;
  logic [31:0] i_addr = '0, i_wdata = '0;
  logic [31:0] o_rdata, o_bus_addr, o_bus_wdata;
  logic        o_done, o_busy, o_err, o_bus_valid, o_bus_we;
  logic [3:0]  o_bus_be;
  logic        i_bus_ready = 1'b0, i_bus_rvalid = 1'b0;
  logic [31:0] i_bus_rdata = '0;

  mem_if #(.TIMEOUT_CYC(TO)) dut (
    .i_clk(clk), .i_rstn(i_rstn), .i_req(i_req), .i_we(i_we), .i_size(i_size),
    .i_uns(i_uns), .i_addr(i_addr), .i_wdata(i_wdata), .o_rdata(o_rdata),
    .o_done(o_done), .o_busy(o_busy), .o_err(o_err), .o_bus_valid(o_bus_valid),
    .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata),
    .o_bus_be(o_bus_be), .i_bus_ready(i_bus_ready), .i_bus_rvalid(i_bus_rvalid),
    .i_bus_rdata(i_bus_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_run = 0, n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  // Expected outputs per cycle; untouched cycles mean an idle interface.
  bit        tl_busy[TLN], tl_valid[TLN], tl_we[TLN], tl_done[TLN], tl_err[TLN], tl_rnew[TLN];
  bit [31:0] tl_addr[TLN], tl_wdata[TLN], tl_rval[TLN];
  bit [3:0]  tl_be[TLN];
  bit [31:0] exp_rdata = '0;

  function automatic bit m_misal(input bit [1:0] sz, input bit [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
  endfunction

  function automatic bit [3:0] m_be(input bit [1:0] sz, input bit [31:0] a);
    if (sz == 2'd0) return 4'(1 << (a % 4));
    if (sz == 2'd1) return (a % 4 >= 2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic bit [31:0] m_wdata(input bit [1:0] sz, input bit [31:0] w);
    if (sz == 2'd0) return (w % 256) * 32'h01010101;
    if (sz == 2'd1) return (w % 65536) * 32'h00010001;
    return w;
  endfunction

  function automatic bit [31:0] m_rdata(input bit [1:0] sz, input bit uns, input bit [31:0] a,
                                        input bit [31:0] r);
    bit [31:0] v;
    if (sz == 2'd0) begin
      v = (r >> (8 * (a % 4))) % 256;
      if (!uns && v >= 128) v = v + 32'hFFFFFF00;
    end else if (sz == 2'd1) begin
      v = (r >> (16 * ((a % 4) / 2))) % 65536;
      if (!uns && v >= 32768) v = v + 32'hFFFF0000;
    end else v = r;
    return v;
  endfunction

  // rd: cycles ready is held low in REQ; vd: cycles rvalid is held low in WAIT_R.
  function automatic void plan(input int t, input bit we, input bit [1:0] sz, input bit uns,
                               input bit [31:0] a, input bit [31:0] w, input int rd,
                               input int vd, input bit [31:0] rdat, output int t_end);
    int c, k, lim, total;
    c = t + 1;
    k = 0;
    lim = 1 << 30;
`ifdef MEM_IF_TIMEOUT_EN
    lim = TO;
`endif
    if (m_misal(sz, a)) begin
      tl_busy[c] = 1; tl_done[c] = 1; tl_err[c] = 1;
      t_end = c;
      return;
    end
    for (int i = 0; i < rd + 1 && k < lim; i++) begin
      tl_busy[c+k] = 1; tl_valid[c+k] = 1; tl_we[c+k] = we;
      tl_addr[c+k] = a - a % 4; tl_be[c+k] = m_be(sz, a); tl_wdata[c+k] = m_wdata(sz, w);
      k++;
    end
    if (!we)
      for (int i = 0; i < vd + 1 && k < lim; i++) begin
        tl_busy[c+k] = 1;
        k++;
      end
    total = rd + 1 + (we ? 0 : vd + 1);
    tl_busy[c+k] = 1; tl_done[c+k] = 1;
    if (total > lim) tl_err[c+k] = 1;
    else if (!we) begin
      tl_rnew[c+k] = 1;
      tl_rval[c+k] = m_rdata(sz, uns, a, rdat);
    end
    t_end = c + k;
  endfunction

  always @(negedge clk) begin
    if (chk_en && cyc < TLN) begin
      if (tl_rnew[cyc]) exp_rdata = tl_rval[cyc];
      chk("busy", o_busy, tl_busy[cyc]);
      chk("bus_valid", o_bus_valid, tl_valid[cyc]);
      chk("bus_we", o_bus_we, tl_we[cyc]);
      chk("bus_addr", o_bus_addr, tl_addr[cyc]);
      chk("bus_be", o_bus_be, tl_be[cyc]);
      chk("bus_wdata", o_bus_wdata, tl_wdata[cyc]);
      chk("done", o_done, tl_done[cyc]);
      chk("err", o_err, tl_err[cyc]);
      chk("rdata", o_rdata, exp_rdata);
    end
  end

  logic [31:0] obs_addr, obs_wdata, obs_rdata;
  logic [3:0]  obs_be;
  logic        obs_valid, obs_done, obs_err;
  int          obs_busy_n, obs_valid_n;

  task automatic txn(input bit we, input bit [1:0] sz, input bit uns, input bit [31:0] a,
                     input bit [31:0] w, input int rd, input int vd, input bit [31:0] rdat,
                     input bit spur, input bit hold, output int t, output int t_end);
    @(posedge clk); #1;
    t = cyc;
    i_req = 1; i_we = we; i_size = sz; i_uns = uns; i_addr = a; i_wdata = w;
    plan(t, we, sz, uns, a, w, rd, vd, rdat, t_end);
    obs_busy_n = 0; obs_valid_n = 0;
    for (int c = t + 1; c <= t_end; c++) begin
      @(posedge clk); #1;
      if (hold) begin
        i_addr = 32'h0000_0FF0; i_wdata = 32'h7777_7777; i_we = ~we;
      end else i_req = 0;
      if (c <= t + 1 + rd) begin
        i_bus_ready = (c == t + 1 + rd);
        i_bus_rvalid = spur && !we;
        i_bus_rdata = spur ? 32'h5555_AAAA : 32'h0;
      end else begin
        i_bus_ready = 0;
        i_bus_rvalid = (c == t + 2 + rd + vd);
        i_bus_rdata = i_bus_rvalid ? rdat : 32'h0;
      end
      if (c == t + 1) begin
        obs_addr = o_bus_addr; obs_be = o_bus_be; obs_wdata = o_bus_wdata; obs_valid = o_bus_valid;
      end
      if (o_busy) obs_busy_n++;
      if (o_bus_valid) obs_valid_n++;
    end
    obs_done = o_done; obs_err = o_err; obs_rdata = o_rdata;
    @(posedge clk); #1;
    i_req = 0; i_bus_ready = 0; i_bus_rvalid = 0; i_bus_rdata = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, te;
    // Model pins
    chk("m_be_h102", m_be(SZ_H, 32'h102), 4'b1100);
    chk("m_wd_h", m_wdata(SZ_H, 32'h1234), 32'h12341234);
    chk("m_rd_b103s", m_rdata(SZ_B, 0, 32'h103, 32'h80000000), 32'hFFFFFF80);
    chk("m_rd_b103u", m_rdata(SZ_B, 1, 32'h103, 32'h80000000), 32'h00000080);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", o_busy, 0); chk("rst_valid", o_bus_valid, 0); chk("rst_done", o_done, 0);
    chk("rst_err", o_err, 0); chk("rst_rdata", o_rdata, 0); chk("rst_be", o_bus_be, 0);
    @(posedge clk); #1;
    i_rstn = 1; chk_en = 1;

    txn(1, SZ_W, 0, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0, 0, t, te);
    chk("w100_lat", te - t, 2); chk("w100_be", obs_be, 4'hF); chk("w100_busy_n", obs_busy_n, 2);
    chk("w100_done", obs_done, 1); chk("w100_wdata", obs_wdata, 32'hDEADBEEF);

    txn(0, SZ_B, 0, 32'h103, 0, 0, 0, 32'h80000000, 0, 0, t, te);
    chk("rb103s_lat", te - t, 3); chk("rb103s_rdata", obs_rdata, 32'hFFFFFF80);
    txn(0, SZ_B, 1, 32'h103, 0, 0, 0, 32'h80000000, 0, 0, t, te);
    chk("rb103u_rdata", obs_rdata, 32'h00000080);

    txn(1, SZ_H, 0, 32'h102, 32'h1234, 0, 0, 0, 0, 0, t, te);
    chk("wh102_be", obs_be, 4'b1100); chk("wh102_wdata", obs_wdata, 32'h12341234);
    chk("wh102_addr", obs_addr, 32'h100);

    txn(0, SZ_W, 0, 32'h101, 0, 0, 0, 32'h11111111, 0, 0, t, te);
    chk("rw101_lat", te - t, 1); chk("rw101_err", obs_err, 1); chk("rw101_done", obs_done, 1);
    chk("rw101_valid_n", obs_valid_n, 0);

    txn(0, SZ_H, 0, 32'h106, 0, 2, 1, 32'h80017FFF, 1, 0, t, te);
    chk("rh106_rdata", obs_rdata, 32'hFFFF8001);
    txn(0, SZ_H, 0, 32'h104, 0, 0, 0, 32'h80017FFF, 0, 0, t, te);
    chk("rh104_rdata", obs_rdata, 32'h00007FFF);

    txn(1, SZ_B, 0, 32'h101, 32'h000000A5, 1, 0, 0, 0, 1, t, te);
    chk("wb101_be", obs_be, 4'b0010); chk("wb101_wdata", obs_wdata, 32'hA5A5A5A5);

    txn(0, SZ_X, 0, 32'h100, 0, 0, 0, 0, 0, 0, t, te);
    chk("sz11_err", obs_err, 1);
    txn(1, SZ_H, 0, 32'h103, 32'hBEEF, 0, 0, 0, 0, 0, t, te);
    chk("wh103_err", obs_err, 1); chk("wh103_valid_n", obs_valid_n, 0);

    txn(0, SZ_W, 0, 32'h10C, 0, 1, 2, 32'hCAFEF00D, 1, 0, t, te);
    chk("rw10c_rdata", obs_rdata, 32'hCAFEF00D);
    txn(0, SZ_B, 1, 32'h102, 0, 0, 0, 32'h00AB0000, 0, 0, t, te);
    chk("rb102u_rdata", obs_rdata, 32'h000000AB);

    txn(1, SZ_W, 0, 32'h300, 32'h01020304, 9, 0, 0, 0, 0, t, te);
`ifdef MEM_IF_TIMEOUT_EN
    chk("to_lat", te - t, 5); chk("to_err", obs_err, 1); chk("to_valid_n", obs_valid_n, 4);
`else
    chk("nto_lat", te - t, 11); chk("nto_err", obs_err, 0); chk("nto_valid_n", obs_valid_n, 10);
`endif

    // Asynchronous reset while waiting for read data
    chk_en = 0;
    @(posedge clk); #1;
    i_req = 1; i_we = 0; i_size = SZ_W; i_uns = 0; i_addr = 32'h200;
    @(posedge clk); #1;
    i_req = 0; i_bus_ready = 1;
    chk("rst_mid_req_valid", o_bus_valid, 1);
    @(posedge clk); #1;
    i_bus_ready = 0;
    chk("rst_mid_wait_busy", o_busy, 1); chk("rst_mid_wait_valid", o_bus_valid, 0);
    #2 i_rstn = 0;
    #1;
    chk("rst_mid_busy", o_busy, 0); chk("rst_mid_valid", o_bus_valid, 0);
    chk("rst_mid_done", o_done, 0); chk("rst_mid_err", o_err, 0);
    chk("rst_mid_rdata", o_rdata, 0); chk("rst_mid_addr", o_bus_addr, 0);
    @(posedge clk); #1;
    chk("rst_hold_busy", o_busy, 0);
    i_rstn = 1; exp_rdata = 0; chk_en = 1;

    txn(1, SZ_B, 0, 32'h403, 32'h0000005A, 0, 0, 0, 0, 0, t, te);
    chk("post_rst_be", obs_be, 4'b1000); chk("post_rst_lat", te - t, 2);

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_if.md
MEM_IF -- requirements
Module: mem_if

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255, SHALL set the bus-wait cycle limit before abort.
REQ-002 i_clk  input  1  SHALL be the clock; all state changes occur on its rising edge.
REQ-003 i_rstn  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 i_req  input  1  SHALL be the request strobe from the control FSM, sampled only in IDLE.
REQ-005 i_we  input  1  SHALL select write (1) or read (0).
REQ-006 i_size  input  2  SHALL select access size: 00 byte, 01 half, 10 word; 11 is illegal.
REQ-007 i_uns  input  1  SHALL select zero-extension (1) or sign-extension (0) of sub-word reads.
REQ-008 i_addr  input  32  SHALL be the byte address.
REQ-009 i_wdata  input  32  SHALL be the store data, right-aligned.
REQ-010 o_rdata  output  32  SHALL be the extended load data, held until the next read completes.
REQ-011 o_done  output  1  SHALL be a one-cycle completion pulse.
REQ-012 o_busy  output  1  SHALL be the stall signal to the control FSM.
REQ-013 o_err  output  1  SHALL be a one-cycle error flag, coincident with o_done.
REQ-014 o_bus_valid, o_bus_we  output  1 each  SHALL be the bus request and its direction.
REQ-015 o_bus_addr  output  32  SHALL be the word-aligned address (addr[1:0]=00).
REQ-016 o_bus_wdata  output  32 and o_bus_be  output  4  SHALL be the lane-aligned data and byte enables.
REQ-017 i_bus_ready, i_bus_rvalid  input  1 each; i_bus_rdata  input  32  SHALL be the bus responses.

Function
REQ-018 The FSM SHALL have states IDLE, REQ, WAIT_R, DONE and ERR.
REQ-019 In IDLE, i_req=1 SHALL register addr/we/size/uns/wdata and go to ERR if misaligned or size=11, otherwise to REQ.
REQ-020 Misaligned SHALL mean half with addr[0]=1, or word with addr[1:0]!=00; no bus access SHALL occur for such requests.
REQ-021 In REQ, o_bus_valid SHALL be 1 with stable bus outputs until i_bus_ready=1.
REQ-022 A write SHALL go REQ->DONE on ready; a read SHALL go REQ->WAIT_R on ready.
REQ-023 i_bus_rvalid SHALL be honoured only in WAIT_R; on rvalid, rdata SHALL be captured and the FSM SHALL go to DONE.
REQ-024 Byte enables SHALL be 0001<<addr[1:0] for byte, 0011<<(2*addr[1]) for half, 1111 for word.
REQ-025 Write data SHALL be replicated across lanes (byte x4, half x2).
REQ-026 Read data SHALL select the addressed lane and sign- or zero-extend it per i_uns.
REQ-027 DONE and ERR SHALL each last one cycle, assert o_done (ERR also o_err), and return to IDLE.
REQ-028 o_busy SHALL be 1 in every state except IDLE; i_req while busy SHALL be ignored.
REQ-029 Minimum latency, measured from the i_req cycle T: write done at T+2, read done at T+3.

Reset
REQ-030 Reset SHALL force IDLE, clear all outputs (o_rdata=0) and drop o_bus_valid immediately, including mid-transaction.

Configuration
REQ-031 Macro MEM_IF_TIMEOUT_EN defined: an 8-bit+ counter in REQ/WAIT_R SHALL abort to ERR on reaching TIMEOUT_CYC cycles.
REQ-032 Counter behaviour: it SHALL clear on entering REQ, and o_bus_valid SHALL drop in the ERR cycle.
REQ-033 Macro MEM_IF_TIMEOUT_EN undefined: no counter SHALL exist, and REQ/WAIT_R SHALL wait indefinitely.

Structure
REQ-034 Package mem_if_pkg SHALL hold the state enum and the size encodings (SZ_B, SZ_H, SZ_W).
REQ-035 Lane steering and extension SHALL live in the combinational sub-module mem_lane_align.

Verification
REQ-036 Word write addr 0x100, data 0xDEADBEEF, ready in the first REQ cycle -> be=1111, done at T+2, busy for 2 cycles.
REQ-037 Byte read addr 0x103, i_uns=0, rdata 0x80000000 -> o_rdata=0xFFFFFF80; with i_uns=1 -> 0x00000080.
REQ-038 Half write addr 0x102, data 0x1234 -> be=1100, o_bus_wdata=0x12341234, o_bus_addr=0x100.
REQ-039 Word read addr 0x101 -> ERR next cycle, o_err=o_done=1, o_bus_valid never asserted.
REQ-040 Ready held 0 with MEM_IF_TIMEOUT_EN and TIMEOUT_CYC=4 -> ERR after 4 REQ cycles; reset asserted in WAIT_R -> outputs 0 and IDLE immediately.
